// File: rtl/div_core.sv
// div_core: iterative radix-2 restoring divider, one quotient bit per cycle.
// Computes quotient and remainder of A / B, signed or unsigned per operation,
// and packs them as {remainder, quotient} for a direct HI/LO write.
//
// Ports:
//   clk        system clock, all state on rising edge
//   resetn     synchronous active-low reset
//   A, B       dividend / divisor, sampled when start is accepted
//   start      request a new division; accepted in IDLE or DONE
//   sign       1 = two's complement operands, 0 = unsigned; sampled with start
//   result     {remainder, quotient}; held until the next accepted start
//   data_ready one-cycle pulse marking the first cycle result is valid
//   busy       high while iterating; start is ignored while high
module div_core #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic                  start,
    input  logic                  sign,
    output logic [2*DATA_W-1:0]   result,
    output logic                  data_ready,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_reg;
    logic [DATA_W:0]      pr_reg;       // partial remainder, one guard bit
    logic [DATA_W-1:0]    q_reg;        // dividend magnitude shifting out, quotient shifting in
    logic [DATA_W-1:0]    b_mag_reg;
    logic [DATA_W-1:0]    a_raw_reg;    // raw dividend, returned as remainder on divide by zero
    logic                 neg_a_reg;
    logic                 neg_b_reg;
    logic                 b_zero_reg;
    logic [CNT_W-1:0]     count_reg;

    // Operand capture path
    logic                 neg_a_in;
    logic                 neg_b_in;
    logic [DATA_W-1:0]    a_mag_in;
    logic [DATA_W-1:0]    b_mag_in;

    // Iteration path
    logic [DATA_W:0]      pr_shift;
    logic [DATA_W-1:0]    q_shift;
    logic [DATA_W+1:0]    trial;
    logic [DATA_W:0]      pr_next;
    logic [DATA_W-1:0]    q_next;
    logic [DATA_W-1:0]    quo_fix;
    logic [DATA_W-1:0]    rem_fix;
    logic [2*DATA_W-1:0]  result_next;

    always_comb begin
        neg_a_in = sign & A[DATA_W-1];
        neg_b_in = sign & B[DATA_W-1];
        // Magnitudes are plain unsigned: negating 0x80..0 yields 0x80..0,
        // which is the correct magnitude when read as unsigned.
        a_mag_in = neg_a_in ? ({DATA_W{1'b0}} - A) : A;
        b_mag_in = neg_b_in ? ({DATA_W{1'b0}} - B) : B;
    end

    always_comb begin
        pr_shift = {pr_reg[DATA_W-1:0], q_reg[DATA_W-1]};
        q_shift  = {q_reg[DATA_W-2:0], 1'b0};
        // One extra bit so the borrow of the trial subtraction is visible.
        trial    = {1'b0, pr_shift} - {2'b00, b_mag_reg};
        pr_next  = pr_shift;
        q_next   = q_shift;
        if (!trial[DATA_W+1]) begin
            pr_next = trial[DATA_W:0];
            q_next  = q_shift | {{(DATA_W-1){1'b0}}, 1'b1};
        end
        // Quotient sign is the XOR of operand signs; remainder follows the dividend.
        quo_fix = (neg_a_reg ^ neg_b_reg) ? ({DATA_W{1'b0}} - q_next) : q_next;
        rem_fix = neg_a_reg ? ({DATA_W{1'b0}} - pr_next[DATA_W-1:0]) : pr_next[DATA_W-1:0];
        result_next = b_zero_reg ? {a_raw_reg, {DATA_W{1'b1}}} : {rem_fix, quo_fix};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            data_ready <= 1'b0;
            result     <= '0;
            count_reg  <= '0;
            pr_reg     <= '0;
            q_reg      <= '0;
            b_mag_reg  <= '0;
            a_raw_reg  <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    // DONE accepts start too, allowing back-to-back divisions.
                    if (start) begin
                        pr_reg     <= '0;
                        q_reg      <= a_mag_in;
                        b_mag_reg  <= b_mag_in;
                        a_raw_reg  <= A;
                        neg_a_reg  <= neg_a_in;
                        neg_b_reg  <= neg_b_in;
                        b_zero_reg <= (B == '0);
                        count_reg  <= '0;
                        busy       <= 1'b1;
                        state_reg  <= CALC;
                    end else begin
                        state_reg  <= IDLE;
                    end
                end
                CALC: begin
                    pr_reg    <= pr_next;
                    q_reg     <= q_next;
                    count_reg <= count_reg + CNT_W'(1);
                    // The final iteration's outputs feed the fix-up directly,
                    // so result is registered on the same edge that enters DONE.
                    if (count_reg == CNT_W'(DATA_W - 1)) begin
                        result     <= result_next;
                        busy       <= 1'b0;
                        data_ready <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_core.sv
// Directed testbench for div_core: reset state, unsigned/signed division,
// extremes, divide by zero, start-while-busy, back-to-back start and
// mid-operation reset. Inputs driven and outputs sampled on the falling edge.
module tb_div_core;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [63:0] result;
    logic        data_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_core #(.DATA_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .A          (A),
        .B          (B),
        .start      (start),
        .sign       (sign),
        .result     (result),
        .data_ready (data_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle N+1.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        A = a;
        B = b;
        sign = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts at cycle N+1 (lat=1); stops at the first data_ready or a bound.
    task automatic wait_ready(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (data_ready !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
        int lat;
        int bc;
        launch(a, b, s);
        check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        wait_ready(lat, bc);
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd32);
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        $display("op %s A=%h B=%h sign=%0d result=%h latency=%0d", tag, a, b, s, result, lat);
        @(negedge clk);
        check({tag, "_ready_pulse"}, {63'd0, data_ready}, 64'd0);
        check({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int lat;
        int bc;
        int early;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ready", {63'd0, data_ready}, 64'd0);
        check("reset_result", result, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic, signed, extremes, divide by zero
        run_op("u_7_2",      32'd7,          32'd2,          1'b0, 64'h00000001_00000003);
        run_op("s_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD);
        run_op("s_7_m2",     32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD);
        run_op("s_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000);
        run_op("u_8000_ffff",32'h80000000,   32'hFFFFFFFF,   1'b0, 64'h80000000_00000000);
        run_op("u_ffff_1",   32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF);
        run_op("div0",       32'h12345678,   32'd0,          1'b1, 64'h12345678_FFFFFFFF);

        // start held during cycles 5..10 of a running op must be ignored
        launch(32'd7, 32'd2, 1'b0);
        early = 0;
        for (int k = 1; k <= 32; k++) begin
            if (k >= 5 && k <= 10) begin
                start = 1'b1;
                A = 32'd100;
                B = 32'd7;
            end else begin
                start = 1'b0;
            end
            if (data_ready === 1'b1) early++;
            if (k == 20) check("busy_ignore_mid", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        check("busy_ignore_early_ready", 64'(early), 64'd0);
        check("busy_ignore_ready", {63'd0, data_ready}, 64'd1);
        check("busy_ignore_result", result, 64'h00000001_00000003);
        $display("op busy_ignore A=%h B=%h sign=0 result=%h", 32'd7, 32'd2, result);

        // Back-to-back: start in the DONE cycle
        A = 32'd100;
        B = 32'd7;
        sign = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_rise", {63'd0, busy}, 64'd1);
        check("b2b_ready_low", {63'd0, data_ready}, 64'd0);
        wait_ready(lat, bc);
        check("b2b_latency", 64'(lat), 64'd33);
        check("b2b_result", result, 64'h00000002_0000000E);
        $display("op b2b A=%h B=%h sign=0 result=%h latency=%0d", 32'd100, 32'd7, result, lat);
        @(negedge clk);
        check("b2b_ready_pulse", {63'd0, data_ready}, 64'd0);

        // Reset at iteration 16 discards the operation
        launch(32'd7, 32'd2, 1'b0);
        repeat (15) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_ready", {63'd0, data_ready}, 64'd0);
        check("midrst_result", result, 64'd0);
        early = 0;
        repeat (40) begin
            @(negedge clk);
            if (data_ready === 1'b1) early++;
        end
        check("midrst_no_ready", 64'(early), 64'd0);
        $display("op midrst A=%h B=%h sign=0 result=%h", 32'd7, 32'd2, result);
        run_op("u_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
